// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD character buffer and its arbiter.
package lcd_pkg;

    localparam int LCD_CHARS = 32;
    localparam int LCD_IDX_W = 5;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // First cell of the second display line; line 1 occupies cells 0-15.
    localparam logic [LCD_IDX_W-1:0] LCD_LINE2_BASE = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CLEAR = 2'd2
    } state_e;

    function automatic logic [LCD_IDX_W-1:0] lcd_cell(input logic line, input logic [3:0] col);
        return line ? (LCD_LINE2_BASE | {1'b0, col}) : {1'b0, col};
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector: first requester at or after the pointer, wrapping.
module lcd_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 2) ? 2 : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_i) + off) % N);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_buffer_arbiter.sv
// 32-cell LCD character buffer with round-robin write arbitration, burst locking
// and a bulk-clear sequencer; the read port feeds LCD_Controller combinationally.
module lcd_buffer_arbiter
    import lcd_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                       CLOCK_50,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [LCD_IDX_W*N_REQ-1:0] wr_index,
    input  logic [8*N_REQ-1:0]         wr_char,
    output logic [N_REQ-1:0]           ack,
    output logic [N_REQ-1:0]           grant,
    input  logic                       clear_req,
    output logic                       clear_busy,
    input  logic [LCD_IDX_W-1:0]       lcd_index,
    output logic [7:0]                 lcd_ascii,
    output state_e                     dbg_state
);

    localparam int PW = (N_REQ > 2) ? 2 : 1;
    localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [LCD_IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [7:0]             mem_q [LCD_CHARS];

    logic                   wr_en;
    logic [LCD_IDX_W-1:0]   wr_addr;
    logic [7:0]             wr_data;
    logic                   own_req, own_lock, xfer, rel;
    logic [N_REQ-1:0]       pick_gnt;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;

    lcd_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign own_req   = req[owner_q];
    assign own_lock  = lock[owner_q];
    assign grant     = grant_q;
    assign dbg_state = state_q;
    assign lcd_ascii = mem_q[lcd_index];

    // Handshake: a requester holds req (with stable wr_index/wr_char) until it sees
    // ack; ack is grant & req, and the write lands on the same clock edge.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        idle_cnt_d = idle_cnt_q;
        clr_cnt_d  = clr_cnt_q;
        ack        = '0;
        clear_busy = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = ASCII_SPACE;
        xfer       = 1'b0;
        rel        = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (pick_any) begin
                    state_d    = GRANT;
                    grant_d    = pick_gnt;
                    owner_d    = pick_idx;
                    idle_cnt_d = '0;
                end
            end
            GRANT: begin
                ack     = grant_q & req;
                xfer    = own_req;
                wr_en   = xfer;
                wr_addr = wr_index[int'(owner_q)*LCD_IDX_W +: LCD_IDX_W];
                wr_data = wr_char[int'(owner_q)*8 +: 8];
                rel     = (xfer && !own_lock) || (!own_req && !own_lock) ||
                          (!xfer && idle_cnt_q == CNT_LAST);
                idle_cnt_d = xfer ? '0 : idle_cnt_q + CW'(1);
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = clr_cnt_q;
                clr_cnt_d  = clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'(LCD_CHARS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            clr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            idle_cnt_q <= idle_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
        end
    end

    // Flip-flop array so the read port can stay combinational.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int i = 0; i < LCD_CHARS; i++) mem_q[i] <= ASCII_SPACE;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lcd_buffer_arbiter.sv
// Self-checking bench for lcd_buffer_arbiter: scenario tasks against a behavioural model.
module tb_lcd_buffer_arbiter;
  import lcd_pkg::*;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, lock, ack, grant;
  logic [5*N-1:0] wr_index;
  logic [8*N-1:0] wr_char;
  logic           clear_req, clear_busy;
  logic [4:0]     lcd_index;
  logic [7:0]     lcd_ascii;
  state_e         dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_mem [32];
  logic [1:0] exp_q [$];
  logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

  lcd_buffer_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(8)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .req(req), .lock(lock),
    .wr_index(wr_index), .wr_char(wr_char), .ack(ack), .grant(grant),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .lcd_index(lcd_index), .lcd_ascii(lcd_ascii), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int i, input logic r, input logic l,
                           input logic [4:0] idx, input logic [7:0] ch);
    req[i] = r;
    lock[i] = l;
    wr_index[i*5 +: 5] = idx;
    wr_char[i*8 +: 8] = ch;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; lock = '0; clear_req = 1'b0;
    wr_index = '0; wr_char = '0; lcd_index = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = ASCII_SPACE;
  endtask

  task automatic fill_all(input logic [7:0] ch);
    @(negedge clk);
    drive_req(0, 1'b1, 1'b1, 5'd0, ch);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      drive_req(0, 1'b1, (k < 31), 5'(k), ch);
    end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 32; i++) model_mem[i] = ch;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", clear_busy); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== 8'h20) begin n_err++; $display("FAIL reset_cell[%0d]: got %h want 20", k, lcd_ascii); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seen [3];
    int got;
    do_reset();
    seen = '{2'b00, 2'b00, 2'b00};
    got = 0;
    drive_req(0, 1'b1, 1'b0, 5'd0, 8'h41);
    drive_req(1, 1'b1, 1'b0, 5'd16, 8'h42);
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk); #1;
      if (grant !== 2'b00) begin
        if (got == 0) begin
          n_cmp++; if (ack !== grant) begin n_err++; $display("FAIL rr_ack_first: got %b want %b", ack, grant); end
        end
        seen[got] = grant;
        got++;
      end
    end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    drive_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    n_cmp++; if (got !== 3) begin n_err++; $display("FAIL rr_grant_count: got %0d want 3", got); end
    n_cmp++; if (seen[0] !== 2'b01) begin n_err++; $display("FAIL rr_grant0: got %b want 01", seen[0]); end
    n_cmp++; if (seen[1] !== 2'b10) begin n_err++; $display("FAIL rr_grant1: got %b want 10", seen[1]); end
    n_cmp++; if (seen[2] !== 2'b01) begin n_err++; $display("FAIL rr_grant2: got %b want 01", seen[2]); end
    model_mem[0] = 8'h41;
    model_mem[16] = 8'h42;
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL rr_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  task automatic test_random_rr();
    int len [2];
    int pend [2];
    int head [2];
    logic [4:0] it_idx [2][6];
    logic [7:0] it_ch [2][6];
    int ptr, w;
    logic [1:0] e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      len[i] = int'($urandom_range(1, 6));
      for (int k = 0; k < 6; k++) begin
        it_idx[i][k] = 5'($urandom_range(0, 31));
        it_ch[i][k] = 8'($urandom_range(33, 126));
      end
    end
    // Reference: each grant serves one pending write of the first pending
    // requester at/after the pointer; pointer then moves past the winner.
    exp_q.delete();
    pend = len;
    ptr = 0;
    while (pend[0] + pend[1] > 0) begin
      w = -1;
      for (int off = 0; off < N; off++)
        if (w < 0 && pend[(ptr + off) % N] > 0) w = (ptr + off) % N;
      exp_q.push_back(2'(1 << w));
      model_mem[it_idx[w][len[w] - pend[w]]] = it_ch[w][len[w] - pend[w]];
      pend[w]--;
      ptr = (w + 1) % N;
    end
    head = '{0, 0};
    for (int c = 0; c < 200; c++) begin
      if (head[0] >= len[0] && head[1] >= len[1]) break;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (head[i] < len[i]) drive_req(i, 1'b1, 1'b0, it_idx[i][head[i]], it_ch[i][head[i]]);
        else drive_req(i, 1'b0, 1'b0, 5'd0, 8'h00);
      end
      #1;
      if (grant !== 2'b00) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
        n_cmp++; if (grant !== e) begin n_err++; $display("FAIL rand_grant: got %b want %b", grant, e); end
        n_cmp++; if (ack !== (grant & req)) begin n_err++; $display("FAIL rand_ack: got %b want %b", ack, grant & req); end
      end
      for (int i = 0; i < 2; i++) if (ack[i] === 1'b1) head[i]++;
    end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    drive_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_pending_grants: got %0d left want 0", exp_q.size()); end
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL rand_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  task automatic test_locked_burst();
    do_reset();
    drive_req(1, 1'b1, 1'b1, 5'd0, hello[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) drive_req(0, 1'b1, 1'b0, 5'd20, 8'h5A);
      drive_req(1, 1'b1, (k < 4), 5'(k), hello[k]);
      #1;
      n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL burst_grant[%0d]: got %b want 10", k, grant); end
      n_cmp++; if (ack !== 2'b10) begin n_err++; $display("FAIL burst_ack[%0d]: got %b want 10", k, ack); end
    end
    @(negedge clk);
    drive_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL burst_idle_gap: got %b want 00", grant); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL burst_idle_state: got %0d want IDLE", dbg_state); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL burst_next_grant: got %b want 01", grant); end
    n_cmp++; if (ack !== 2'b01) begin n_err++; $display("FAIL burst_next_ack: got %b want 01", ack); end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int k = 0; k < 5; k++) model_mem[k] = hello[k];
    model_mem[20] = 8'h5A;
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL burst_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  task automatic test_lock_timeout();
    int held;
    do_reset();
    drive_req(0, 1'b1, 1'b1, 5'd3, 8'h4B);
    drive_req(1, 1'b1, 1'b0, 5'd31, 8'h51);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b1, 5'd3, 8'h4B);
    #1;
    held = 0;
    for (int c = 0; c < 20; c++) begin
      if (grant !== 2'b01) break;
      held++;
      @(negedge clk); #1;
    end
    n_cmp++; if (held !== 8) begin n_err++; $display("FAIL timeout_hold: got %0d cycles want 8", held); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL timeout_release: got %b want 00", grant); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL timeout_next_grant: got %b want 10", grant); end
    n_cmp++; if (ack !== 2'b10) begin n_err++; $display("FAIL timeout_next_ack: got %b want 10", ack); end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    drive_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    model_mem[31] = 8'h51;
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL timeout_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  task automatic test_clear();
    int busy, ack_seen;
    do_reset();
    fill_all(8'h58);
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL fill_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
    @(negedge clk);
    clear_req = 1'b1;
    drive_req(0, 1'b1, 1'b0, 5'd5, 8'h59);
    busy = 0;
    ack_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (clear_busy !== 1'b1) break;
      busy++;
      if (ack !== 2'b00) ack_seen++;
    end
    n_cmp++; if (busy !== 32) begin n_err++; $display("FAIL clear_busy_len: got %0d want 32", busy); end
    n_cmp++; if (ack_seen !== 0) begin n_err++; $display("FAIL clear_ack: got %0d acked cycles want 0", ack_seen); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL clear_idle_gap: got %b want 00", grant); end
    @(negedge clk); #1;
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL clear_then_grant: got %b want 01", grant); end
    n_cmp++; if (ack !== 2'b01) begin n_err++; $display("FAIL clear_then_ack: got %b want 01", ack); end
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 32; i++) model_mem[i] = ASCII_SPACE;
    model_mem[5] = 8'h59;
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL clear_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy;
    do_reset();
    fill_all(8'h58);
    @(negedge clk);
    clear_req = 1'b1;
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (clear_busy === 1'b1) busy++;
      if (busy == 11) break;
    end
    n_cmp++; if (busy !== 11) begin n_err++; $display("FAIL midclr_reach: got %0d busy cycles want 11", busy); end
    reset_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL midclr_state: got %0d want IDLE", dbg_state); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL midclr_busy: got %b want 0", clear_busy); end
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL midclr_grant: got %b want 00", grant); end
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = ASCII_SPACE;
    for (int k = 0; k < 32; k++) begin
      lcd_index = 5'(k); #1;
      n_cmp++; if (lcd_ascii !== model_mem[k]) begin n_err++; $display("FAIL midclr_cell[%0d]: got %h want %h", k, lcd_ascii, model_mem[k]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_random_rr();
    test_random_rr();
    test_locked_burst();
    test_lock_timeout();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
